// File: rtl/rf_cmd_pkg.sv
// Shared definitions for the register-file command controller:
// frame opcodes, the error response code and the parser FSM states.
package rf_cmd_pkg;

  localparam logic [7:0] CMD_WR   = 8'hAA;
  localparam logic [7:0] CMD_RD   = 8'hBB;
  localparam logic [7:0] ERR_CODE = 8'hEE;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ADDR  = 3'd1,
    WR_DATA  = 3'd2,
    RD_ADDR  = 3'd3,
    RD_ISSUE = 3'd4,
    RD_WAIT  = 3'd5,
    TX_SEND  = 3'd6
  } state_t;

  // States that are in the middle of collecting frame bytes.
  function automatic logic in_frame(state_t s);
    return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR);
  endfunction

  // States in which incoming bytes cannot be parsed and are dropped.
  function automatic logic is_busy(state_t s);
    return (s == RD_ISSUE) || (s == RD_WAIT) || (s == TX_SEND);
  endfunction

endpackage

// File: rtl/rf_cmd_ctrl_if.sv
// Bundle of the UART-side and register-file-side signals of rf_cmd_ctrl.
//
// Handshake semantics:
//   rx_valid  : one-cycle strobe, no backpressure; rx_data valid only in that cycle.
//   tx_valid/tx_ready : tx_data is transferred on every cycle where both are
//     high; once tx_valid rises, tx_valid and tx_data stay stable until that
//     transfer cycle, and tx_valid is low the cycle after the transfer.
//   rf_wr_en/rf_rd_en : one-cycle strobes, never high together; rf_rd_data is
//     valid the cycle after rf_rd_en.
interface rf_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rf_wr_en;
  logic                  rf_rd_en;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_wr_data;
  logic [DATA_WIDTH-1:0] rf_rd_data;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  rx_drop;

  // Controller side.
  modport master (
    input  rx_data, rx_valid, rf_rd_data, tx_ready,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, tx_data, tx_valid, rx_drop
  );

  // UART / register-file side.
  modport slave (
    output rx_data, rx_valid, rf_rd_data, tx_ready,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, tx_data, tx_valid, rx_drop
  );
endinterface

// File: rtl/rf_cmd_timeout.sv
// Loadable down-counter used to abort stalled partial frames.
// expire_o is high while enabled, not loading, and the count has run out.
module rf_cmd_timeout #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expire_o
);
  logic [WIDTH-1:0] cnt_q;

  // Reload on demand, otherwise count down to zero while enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = en_i && !load_i && (cnt_q == '0);
endmodule

// File: rtl/rf_cmd_ctrl.sv
// Byte-oriented command controller in front of the register file.
// Parses write (AA addr data) and read (BB addr) frames from the UART receive
// path, strobes the register file and returns read data / error code on tx.
// Optional feature: define RF_CMD_TIMEOUT_EN to abort partial frames after
// TIMEOUT_CYCLES idle cycles; without it a partial frame waits indefinitely.
module rf_cmd_ctrl
  import rf_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int RF_DEPTH       = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            rst,
  rf_cmd_ctrl_if.master   bus,
  output state_t          dbg_state_o
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(RF_DEPTH);
  localparam logic [DATA_WIDTH-1:0] CMD_WR_C = DATA_WIDTH'(CMD_WR);
  localparam logic [DATA_WIDTH-1:0] CMD_RD_C = DATA_WIDTH'(CMD_RD);
  localparam logic [DATA_WIDTH-1:0] ERR_C    = DATA_WIDTH'(ERR_CODE);

  // Reject parameter sets the address decode cannot represent.
  if (RF_DEPTH < 1 || RF_DEPTH > (1 << ADDR_WIDTH) || DATA_WIDTH <= ADDR_WIDTH ||
      TIMEOUT_CYCLES < 2) begin : g_param_err
    $error("rf_cmd_ctrl: unsupported parameter combination");
  end

  state_t                state_q;
  logic                  wr_en_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  addr_ok_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_valid_q;
  logic                  addr_ok;
  logic                  tmo_expire;

  // Address byte is valid when its upper bits are clear and it is in range.
  assign addr_ok = ((bus.rx_data >> ADDR_WIDTH) == '0) &&
                   ({1'b0, bus.rx_data[ADDR_WIDTH-1:0]} < DEPTH_C);

`ifdef RF_CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic tmo_en;
  assign tmo_en = in_frame(state_q);

  rf_cmd_timeout #(.WIDTH(TMO_W)) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .load_i     (bus.rx_valid || !tmo_en),
    .en_i       (tmo_en),
    .load_val_i (TMO_W'(TIMEOUT_CYCLES - 1)),
    .expire_o   (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  // Frame parser and response sequencer; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      addr_ok_q  <= 1'b0;
      wr_data_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == CMD_WR_C)      state_q <= WR_ADDR;
            else if (bus.rx_data == CMD_RD_C) state_q <= RD_ADDR;
          end
        end
        WR_ADDR: begin
          if (bus.rx_valid) begin
            addr_q    <= bus.rx_data[ADDR_WIDTH-1:0];
            addr_ok_q <= addr_ok;
            state_q   <= WR_DATA;
          end else if (tmo_expire) begin
            state_q <= IDLE;
          end
        end
        WR_DATA: begin
          if (bus.rx_valid) begin
            wr_data_q <= bus.rx_data;
            wr_en_q   <= addr_ok_q;
            state_q   <= IDLE;
          end else if (tmo_expire) begin
            state_q <= IDLE;
          end
        end
        RD_ADDR: begin
          if (bus.rx_valid) begin
            addr_q <= bus.rx_data[ADDR_WIDTH-1:0];
            if (addr_ok) begin
              rd_en_q <= 1'b1;
              state_q <= RD_ISSUE;
            end else begin
              tx_data_q  <= ERR_C;
              tx_valid_q <= 1'b1;
              state_q    <= TX_SEND;
            end
          end else if (tmo_expire) begin
            state_q <= IDLE;
          end
        end
        RD_ISSUE: state_q <= RD_WAIT;
        RD_WAIT: begin
          tx_data_q  <= bus.rf_rd_data;
          tx_valid_q <= 1'b1;
          state_q    <= TX_SEND;
        end
        TX_SEND: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rf_wr_en   = wr_en_q;
  assign bus.rf_rd_en   = rd_en_q;
  assign bus.rf_addr    = addr_q;
  assign bus.rf_wr_data = wr_data_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  // Drop indication must coincide with the discarded byte, so it is combinational.
  assign bus.rx_drop    = !rst && bus.rx_valid && is_busy(state_q);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Self-checking bench for rf_cmd_ctrl: directed scenarios plus randomized
// frames checked against a frame-level reference model and expected queues.
module tb_rf_cmd_ctrl;
  import rf_cmd_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic mem_clr;
  always #5 clk = ~clk;

  rf_cmd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  state_t dbg_state;

  rf_cmd_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RF_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- register file stand-in ----------------
  logic [DW-1:0] rf_mem [0:15];
  logic [DW-1:0] rd_data_q;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (bus.rf_wr_en === 1'b1) rf_mem[bus.rf_addr] <= bus.rf_wr_data;
      if (bus.rf_rd_en === 1'b1) rd_data_q <= rf_mem[bus.rf_addr];
    end
  end
  assign bus.rf_rd_data = rd_data_q;

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0]    ref_mem [0:15];
  logic [AW+DW-1:0] exp_wr_q[$];
  logic [AW-1:0]    exp_rd_q[$];
  logic [DW-1:0]    exp_tx_q[$];
  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int drop_cnt = 0;

  // Monitor: every strobe and every tx transfer is matched against the queues.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.rf_wr_en === 1'b1) begin
        wr_cnt++;
        checks++;
        if (exp_wr_q.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected addr=%0d data=%h", bus.rf_addr, bus.rf_wr_data);
        end else begin
          logic [AW+DW-1:0] e;
          e = exp_wr_q.pop_front();
          if ({bus.rf_addr, bus.rf_wr_data} !== e) begin
            failures++;
            $display("FAIL wr_content got=%h exp=%h", {bus.rf_addr, bus.rf_wr_data}, e);
          end
        end
      end
      if (bus.rf_rd_en === 1'b1) begin
        rd_cnt++;
        checks++;
        if (exp_rd_q.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected addr=%0d", bus.rf_addr);
        end else begin
          logic [AW-1:0] e;
          e = exp_rd_q.pop_front();
          if (bus.rf_addr !== e) begin
            failures++;
            $display("FAIL rd_addr got=%0d exp=%0d", bus.rf_addr, e);
          end
        end
      end
      if (bus.rf_wr_en === 1'b1 || bus.rf_rd_en === 1'b1) begin
        checks++;
        if (bus.rf_wr_en === 1'b1 && bus.rf_rd_en === 1'b1) begin
          failures++;
          $display("FAIL strobe_overlap wr=1 rd=1 exp=not both");
        end
      end
      if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
        checks++;
        if (exp_tx_q.size() == 0) begin
          failures++;
          $display("FAIL tx_unexpected data=%h", bus.tx_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_tx_q.pop_front();
          if (bus.tx_data !== e) begin
            failures++;
            $display("FAIL tx_data got=%h exp=%h", bus.tx_data, e);
          end
        end
      end
      if (bus.rx_drop === 1'b1) drop_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [DW-1:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_tx_done(input bit rand_ready);
    int n = 0;
    while (exp_tx_q.size() != 0 && n < 200) begin
      if (rand_ready) bus.tx_ready = 1'($urandom_range(0, 1));
      else bus.tx_ready = 1'b1;
      step();
      n++;
    end
    bus.tx_ready = 1'b1;
    checks++;
    if (exp_tx_q.size() != 0) begin
      failures++;
      $display("FAIL tx_timeout pending=%0d exp=0", exp_tx_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; mem_clr = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (3) step();
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    checks++; if (bus.rf_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", bus.rf_wr_en); end
    checks++; if (bus.rf_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", bus.rf_rd_en); end
    checks++; if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
    checks++; if (bus.rx_drop !== 1'b0) begin failures++; $display("FAIL reset_rx_drop got=%b exp=0", bus.rx_drop); end
    checks++; if (bus.rf_addr !== '0) begin failures++; $display("FAIL reset_rf_addr got=%h exp=0", bus.rf_addr); end
    checks++; if (bus.rf_wr_data !== '0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0", bus.rf_wr_data); end
    checks++; if (bus.tx_data !== '0) begin failures++; $display("FAIL reset_tx_data got=%h exp=0", bus.tx_data); end
    step();
  endtask

  task automatic test_write();
    ref_mem[3] = 8'h5C;
    exp_wr_q.push_back({4'd3, 8'h5C});
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h5C);
    @(negedge clk);
    checks++; if (bus.rf_wr_en !== 1'b1) begin failures++; $display("FAIL write_strobe got=%b exp=1", bus.rf_wr_en); end
    checks++; if (bus.rf_addr !== 4'd3) begin failures++; $display("FAIL write_addr got=%0d exp=3", bus.rf_addr); end
    checks++; if (bus.rf_wr_data !== 8'h5C) begin failures++; $display("FAIL write_data got=%h exp=5c", bus.rf_wr_data); end
    step();
    @(negedge clk);
    checks++; if (bus.rf_wr_en !== 1'b0) begin failures++; $display("FAIL write_one_cycle got=%b exp=0", bus.rf_wr_en); end
    step();
  endtask

  task automatic test_read();
    bus.tx_ready = 1'b1;
    exp_rd_q.push_back(4'd3);
    exp_tx_q.push_back(ref_mem[3]);
    send_byte(8'hBB); send_byte(8'h03);
    @(negedge clk);
    checks++; if (bus.rf_rd_en !== 1'b1) begin failures++; $display("FAIL read_strobe got=%b exp=1", bus.rf_rd_en); end
    checks++; if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL read_early_valid got=%b exp=0", bus.tx_valid); end
    step();
    @(negedge clk);
    checks++; if (bus.rf_rd_en !== 1'b0 || bus.tx_valid !== 1'b0) begin
      failures++; $display("FAIL read_wait rd_en=%b tx_valid=%b exp=0,0", bus.rf_rd_en, bus.tx_valid);
    end
    step();
    @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b1) begin failures++; $display("FAIL read_tx_valid got=%b exp=1", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h5C) begin failures++; $display("FAIL read_tx_data got=%h exp=5c", bus.tx_data); end
    step();
    @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL read_tx_drop got=%b exp=0", bus.tx_valid); end
    step();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    int n = 0;
    int drops0, wr0;
    d = 8'($urandom_range(0, 255));
    ref_mem[5] = d;
    exp_wr_q.push_back({4'd5, d});
    send_byte(8'hAA); send_byte(8'h05); send_byte(d);
    step();
    bus.tx_ready = 1'b0;
    exp_rd_q.push_back(4'd5);
    send_byte(8'hBB); send_byte(8'h05);
    while (bus.tx_valid !== 1'b1 && n < 10) begin step(); n++; end
    checks++; if (n >= 10) begin failures++; $display("FAIL bp_valid_timeout got=0 exp=1"); end
    drops0 = drop_cnt; wr0 = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin bus.rx_data = 8'h11; bus.rx_valid = 1'b1; end
      @(negedge clk);
      checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== d) begin
        failures++; $display("FAIL bp_stable cyc=%0d valid=%b data=%h exp=1,%h", i, bus.tx_valid, bus.tx_data, d);
      end
      if (i == 4) begin
        checks++; if (bus.rx_drop !== 1'b1) begin failures++; $display("FAIL bp_drop_pulse got=%b exp=1", bus.rx_drop); end
      end
      step();
      bus.rx_valid = 1'b0;
    end
    checks++; if (drop_cnt - drops0 != 1) begin failures++; $display("FAIL bp_drop_count got=%0d exp=1", drop_cnt - drops0); end
    exp_tx_q.push_back(d);
    wait_tx_done(1'b0);
    step();
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL bp_state got=%0d exp=%0d", dbg_state, IDLE); end
    checks++; if (wr_cnt != wr0) begin failures++; $display("FAIL bp_parsed_drop writes=%0d exp=%0d", wr_cnt, wr0); end
  endtask

  task automatic test_invalid();
    int wr0, rd0;
    wr0 = wr_cnt; rd0 = rd_cnt;
    send_byte(8'h17);
    send_byte(8'hAA); send_byte(8'h09); send_byte(8'h22);
    send_byte(8'hAA); send_byte(8'h13); send_byte(8'h55);
    repeat (3) step();
    checks++; if (wr_cnt != wr0) begin failures++; $display("FAIL inv_write writes=%0d exp=%0d", wr_cnt, wr0); end
    bus.tx_ready = 1'b1;
    exp_tx_q.push_back(8'hEE);
    send_byte(8'hBB); send_byte(8'h09);
    @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b1) begin failures++; $display("FAIL inv_err_valid got=%b exp=1", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'hEE) begin failures++; $display("FAIL inv_err_data got=%h exp=ee", bus.tx_data); end
    step();
    wait_tx_done(1'b0);
    step();
    checks++; if (rd_cnt != rd0) begin failures++; $display("FAIL inv_read_strobe reads=%0d exp=%0d", rd_cnt, rd0); end
  endtask

  task automatic test_reset_mid();
    int wr0;
    int n = 0;
    wr0 = wr_cnt;
    send_byte(8'hAA); send_byte(8'h02);
    rst = 1'b1; step(); rst = 1'b0;
    @(negedge clk);
    checks++; if (dbg_state !== IDLE || bus.rf_wr_en !== 1'b0 || bus.rf_rd_en !== 1'b0 ||
                 bus.tx_valid !== 1'b0 || bus.rf_addr !== '0 || bus.rf_wr_data !== '0 ||
                 bus.tx_data !== '0 || bus.rx_drop !== 1'b0) begin
      failures++; $display("FAIL rstmid_outputs state=%0d wr=%b rd=%b txv=%b addr=%h exp=all 0",
                           dbg_state, bus.rf_wr_en, bus.rf_rd_en, bus.tx_valid, bus.rf_addr);
    end
    step();
    send_byte(8'h44);
    repeat (3) step();
    checks++; if (wr_cnt != wr0) begin failures++; $display("FAIL rstmid_write writes=%0d exp=%0d", wr_cnt, wr0); end
    // reset while a response is waiting for the transmitter
    bus.tx_ready = 1'b0;
    exp_rd_q.push_back(4'd3);
    send_byte(8'hBB); send_byte(8'h03);
    while (bus.tx_valid !== 1'b1 && n < 10) begin step(); n++; end
    checks++; if (n >= 10) begin failures++; $display("FAIL rstmid_valid_timeout got=0 exp=1"); end
    rst = 1'b1; step();
    @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_tx_valid got=%b exp=0", bus.tx_valid); end
    step();
    rst = 1'b0; bus.tx_ready = 1'b1;
    step();
  endtask

  task automatic test_partial_frame();
    int wr0;
    wr0 = wr_cnt;
    send_byte(8'hAA);
    repeat (20) step();
`ifdef RF_CMD_TIMEOUT_EN
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL tmo_state got=%0d exp=%0d", dbg_state, IDLE); end
    send_byte(8'h01);
    send_byte(8'h33);
    repeat (2) step();
    checks++; if (wr_cnt != wr0) begin failures++; $display("FAIL tmo_write writes=%0d exp=%0d", wr_cnt, wr0); end
`else
    checks++; if (dbg_state !== WR_ADDR) begin failures++; $display("FAIL hold_state got=%0d exp=%0d", dbg_state, WR_ADDR); end
    ref_mem[1] = 8'h33;
    exp_wr_q.push_back({4'd1, 8'h33});
    send_byte(8'h01);
    send_byte(8'h33);
    repeat (2) step();
    checks++; if (wr_cnt != wr0 + 1) begin failures++; $display("FAIL hold_write writes=%0d exp=%0d", wr_cnt, wr0 + 1); end
`endif
  endtask

  task automatic test_random();
    for (int f = 0; f < 60; f++) begin
      int kind;
      logic [DW-1:0] a, d;
      kind = $urandom_range(0, 3);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, DEPTH - 1));
      d = 8'($urandom_range(0, 255));
      if (kind == 0) begin
        if (d == 8'hAA || d == 8'hBB) d = 8'h00;
        send_byte(d);
      end else if (kind == 1) begin
        if (a < DEPTH) begin
          exp_wr_q.push_back({a[AW-1:0], d});
          ref_mem[a[AW-1:0]] = d;
        end
        send_byte(8'hAA);
        repeat ($urandom_range(0, 2)) step();
        send_byte(a);
        repeat ($urandom_range(0, 2)) step();
        send_byte(d);
      end else begin
        if (a < DEPTH) begin
          exp_rd_q.push_back(a[AW-1:0]);
          exp_tx_q.push_back(ref_mem[a[AW-1:0]]);
        end else begin
          exp_tx_q.push_back(8'hEE);
        end
        send_byte(8'hBB);
        repeat ($urandom_range(0, 2)) step();
        send_byte(a);
        wait_tx_done(1'b1);
      end
    end
    repeat (3) step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_invalid();
    test_reset_mid();
    test_partial_frame();
    test_random();
    checks++; if (exp_wr_q.size() != 0) begin failures++; $display("FAIL end_wr_queue pending=%0d exp=0", exp_wr_q.size()); end
    checks++; if (exp_rd_q.size() != 0) begin failures++; $display("FAIL end_rd_queue pending=%0d exp=0", exp_rd_q.size()); end
    checks++; if (exp_tx_q.size() != 0) begin failures++; $display("FAIL end_tx_queue pending=%0d exp=0", exp_tx_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_cmd_ctrl.md
# rf_cmd_ctrl

Byte-oriented command controller sitting directly upstream of the register file. It parses command frames arriving from the UART receive path, drives the register file's write and read strobes, and returns read data to the UART transmit path over a valid/ready handshake. It owns all sequencing between the serial link and register storage.

## Interface
- DATA_WIDTH, 8: width of register data and of every frame byte
- ADDR_WIDTH, 4: register file address width
- RF_DEPTH, 8: number of implemented registers; addresses ≥ RF_DEPTH are invalid
- TIMEOUT_CYCLES, 4096: idle cycles before a partial frame is aborted (used only with the timeout feature)

- clk  input  1  single system clock, rising edge
- rst  input  1  synchronous, active-high reset
- rx_data  input  DATA_WIDTH  received byte
- rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle
- rf_wr_en  output  1  register file write strobe
- rf_rd_en  output  1  register file read strobe
- rf_addr  output  ADDR_WIDTH  register file address
- rf_wr_data  output  DATA_WIDTH  register file write data
- rf_rd_data  input  DATA_WIDTH  register file read data, valid the cycle after rf_rd_en
- tx_data  output  DATA_WIDTH  response byte
- tx_valid  output  1  response available
- tx_ready  input  1  transmitter accepts tx_data when tx_valid && tx_ready
- rx_drop  output  1  one-cycle pulse: a byte arrived while busy and was discarded

## Operation
- Frames: write = CMD_WR (0xAA), addr, data; read = CMD_RD (0xBB), addr. Address byte uses its low ADDR_WIDTH bits; the upper bits must be zero, otherwise the address is invalid.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_ISSUE, RD_WAIT, TX_SEND.
- IDLE: byte 0xAA → WR_ADDR; 0xBB → RD_ADDR; any other byte ignored (no drop pulse).
- WR_ADDR: byte latched as address → WR_DATA.
- WR_DATA: byte latched → IDLE; next cycle rf_wr_en=1 for exactly one cycle with rf_addr/rf_wr_data, unless address invalid (write silently discarded).
- RD_ADDR: byte latched → RD_ISSUE if valid, else load tx_data=ERR_CODE (0xEE) → TX_SEND.
- RD_ISSUE: rf_rd_en=1 one cycle → RD_WAIT.
- RD_WAIT: capture rf_rd_data into tx_data → TX_SEND.
- TX_SEND: tx_valid=1, tx_data held stable until tx_ready sampled high → IDLE.
- rx_valid in RD_ISSUE, RD_WAIT or TX_SEND: byte discarded, rx_drop pulses same cycle.
- rf_wr_en and rf_rd_en are never high together.

## Timing
- Reset values: state IDLE; rf_wr_en, rf_rd_en, tx_valid, rx_drop = 0; rf_addr, rf_wr_data, tx_data = 0.
- Write latency: rf_wr_en asserted the cycle after data byte's rx_valid.
- Read latency: rf_rd_en the cycle after address byte; tx_valid rises 2 cycles after rf_rd_en; invalid-address error response: tx_valid the cycle after address byte.
- tx handshake: transfer on the cycle tx_valid && tx_ready; tx_valid low the following cycle; a back-to-back command byte may be accepted in that same following cycle.
- Reset asserted mid-frame or mid-handshake: frame abandoned, no strobe issued afterwards, tx_valid drops the next cycle.

## Configuration
- RF_CMD_TIMEOUT_EN defined: counter runs in WR_ADDR, WR_DATA, RD_ADDR; reloads on each rx_valid; on reaching TIMEOUT_CYCLES the FSM returns to IDLE with no strobe issued. Not active in RD_* or TX_SEND (TX may wait indefinitely).
- Not defined: no counter logic; a partial frame waits indefinitely.

## Structure
- Shared package rf_cmd_pkg: CMD_WR, CMD_RD, ERR_CODE constants and the FSM state enum.
- One sub-module: rf_cmd_timeout (loadable down-counter with expiry pulse), instantiated only under RF_CMD_TIMEOUT_EN.

## Test plan
- Bytes 0xAA,0x03,0x5C → one cycle rf_wr_en=1, rf_addr=3, rf_wr_data=0x5C, the cycle after the 0x5C strobe.
- Bytes 0xBB,0x03 with model returning 0x5C → rf_rd_en one cycle, tx_valid 2 cycles later with tx_data=0x5C.
- Read with tx_ready low 10 cycles, byte 0x11 sent meanwhile → tx_valid/tx_data stable, rx_drop pulses once, 0x11 not parsed.
- Bytes 0x17 then 0xAA,0x09,0x22 → 0x17 ignored, no rf_wr_en; 0xBB,0x09 → tx_data=0xEE, no rf_rd_en.
- rst pulsed after 0xAA,0x02 → all outputs 0; subsequent 0x44 ignored, no write.
- With RF_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16: 0xAA then 20 idle cycles then 0x01 → back in IDLE, 0x01 ignored, no write.
